// File: rtl/dmem_bus_responder.sv
// Memory-side responder for the data-memory request/response handshake, with fixed wait states.
// Optional load/store/error counters are enabled by defining DMEM_STATS_EN.
module dmem_bus_responder #(
   parameter int ADDR_W      = 16,
   parameter int DATA_W      = 16,
   parameter int DEPTH       = 256,
   parameter int WAIT_CYCLES = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   input  logic              req_we,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              req_ready,
   output logic              rsp_valid,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              rsp_err,
   output logic [15:0]       stat_rd,
   output logic [15:0]       stat_wr,
   output logic [15:0]       stat_err
);

   localparam int IDX_W  = ADDR_W - 1;
   localparam int MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [3:0]        WAIT_LAST = 4'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);
   localparam logic [ADDR_W-1:0] DEPTH_L   = ADDR_W'(DEPTH);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;

   state_e            state_q, state_d;
   logic [3:0]        cnt_q, cnt_d;
   logic              we_q, we_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic              err_q, err_d;

   logic [DATA_W-1:0] mem [DEPTH];

   logic              cur_we;
   logic [ADDR_W-1:0] cur_addr;
   logic [DATA_W-1:0] cur_wdata;
   logic [IDX_W-1:0]  idx;
   logic [MEM_AW-1:0] mem_idx;
   logic              addr_err;
   logic              enter_resp;
   logic              mem_we;

   // With zero wait states RESP is entered on the accept edge, so decode the live request there.
   assign cur_we    = (state_q == S_IDLE) ? req_we    : we_q;
   assign cur_addr  = (state_q == S_IDLE) ? req_addr  : addr_q;
   assign cur_wdata = (state_q == S_IDLE) ? req_wdata : wdata_q;
   assign idx       = cur_addr[ADDR_W-1:1];
   assign mem_idx   = idx[MEM_AW-1:0];
   assign addr_err  = cur_addr[0] | ({1'b0, idx} >= DEPTH_L);

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      we_d       = we_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      rdata_d    = rdata_q;
      err_d      = err_q;
      enter_resp = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (req_valid) begin
               we_d    = req_we;
               addr_d  = req_addr;
               wdata_d = req_wdata;
               cnt_d   = 4'd0;
               if (WAIT_CYCLES == 0) begin
                  state_d    = S_RESP;
                  enter_resp = 1'b1;
               end else begin
                  state_d = S_WAIT;
               end
            end
         end
         S_WAIT: begin
            if (cnt_q == WAIT_LAST) begin
               state_d    = S_RESP;
               enter_resp = 1'b1;
               cnt_d      = 4'd0;
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         S_RESP:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      if (enter_resp) begin
         err_d   = addr_err;
         rdata_d = (cur_we || addr_err) ? '0 : mem[mem_idx];
      end
   end

   assign mem_we = enter_resp & cur_we & ~addr_err;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= 4'd0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
      end
   end

   // Storage is deliberately not reset; a reset edge still suppresses a pending store.
   always_ff @(posedge clk) begin
      if (!rst && mem_we) mem[mem_idx] <= cur_wdata;
   end

   assign req_ready = (state_q == S_IDLE);
   assign rsp_valid = (state_q == S_RESP);
   assign rsp_rdata = rdata_q;
   assign rsp_err   = err_q;

`ifdef DMEM_STATS_EN
   logic [15:0] stat_rd_q, stat_rd_d;
   logic [15:0] stat_wr_q, stat_wr_d;
   logic [15:0] stat_err_q, stat_err_d;

   always_comb begin
      stat_rd_d  = stat_rd_q;
      stat_wr_d  = stat_wr_q;
      stat_err_d = stat_err_q;
      if (state_q == S_RESP) begin
         if (err_q)     stat_err_d = (stat_err_q == 16'hFFFF) ? stat_err_q : stat_err_q + 16'd1;
         else if (we_q) stat_wr_d  = (stat_wr_q  == 16'hFFFF) ? stat_wr_q  : stat_wr_q  + 16'd1;
         else           stat_rd_d  = (stat_rd_q  == 16'hFFFF) ? stat_rd_q  : stat_rd_q  + 16'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         stat_rd_q  <= 16'd0;
         stat_wr_q  <= 16'd0;
         stat_err_q <= 16'd0;
      end else begin
         stat_rd_q  <= stat_rd_d;
         stat_wr_q  <= stat_wr_d;
         stat_err_q <= stat_err_d;
      end
   end

   assign stat_rd  = stat_rd_q;
   assign stat_wr  = stat_wr_q;
   assign stat_err = stat_err_q;
`else
   assign stat_rd  = 16'd0;
   assign stat_wr  = 16'd0;
   assign stat_err = 16'd0;
`endif

endmodule

// File: tb/tb_dmem_bus_responder.sv
// Directed bench for dmem_bus_responder: a WAIT_CYCLES=2 instance plus 0- and 3-wait instances
// sharing the same request inputs for the back-to-back throughput checks.
module tb_dmem_bus_responder;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid, req_we;
   logic [15:0] req_addr, req_wdata;

   logic        req_ready, rsp_valid, rsp_err;
   logic [15:0] rsp_rdata, stat_rd, stat_wr, stat_err;
   logic        req_ready_z, rsp_valid_z, rsp_err_z;
   logic [15:0] rsp_rdata_z, stat_rd_z, stat_wr_z, stat_err_z;
   logic        req_ready_t, rsp_valid_t, rsp_err_t;
   logic [15:0] rsp_rdata_t, stat_rd_t, stat_wr_t, stat_err_t;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   dmem_bus_responder #(.WAIT_CYCLES(2)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr),
      .req_wdata(req_wdata), .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
      .rsp_err(rsp_err), .stat_rd(stat_rd), .stat_wr(stat_wr), .stat_err(stat_err));

   dmem_bus_responder #(.WAIT_CYCLES(0)) dut_z (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr),
      .req_wdata(req_wdata), .req_ready(req_ready_z), .rsp_valid(rsp_valid_z), .rsp_rdata(rsp_rdata_z),
      .rsp_err(rsp_err_z), .stat_rd(stat_rd_z), .stat_wr(stat_wr_z), .stat_err(stat_err_z));

   dmem_bus_responder #(.WAIT_CYCLES(3)) dut_t (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr),
      .req_wdata(req_wdata), .req_ready(req_ready_t), .rsp_valid(rsp_valid_t), .rsp_rdata(rsp_rdata_t),
      .rsp_err(rsp_err_t), .stat_rd(stat_rd_t), .stat_wr(stat_wr_t), .stat_err(stat_err_t));

   typedef struct {
      logic        we;
      logic [15:0] addr;
      logic [15:0] wdata;
      logic [15:0] exp_rd;
      logic        exp_err;
   } vec_t;

   vec_t tbl[10];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      req_valid = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   // One transaction on the 2-wait instance: response expected on the 3rd cycle after accept.
   task automatic txn(input int n, input logic we, input logic [15:0] addr, input logic [15:0] wdata,
                      input logic [15:0] exp_rd, input logic exp_err);
      int lat;
      logic [15:0] rd;
      @(negedge clk);
      chk($sformatf("v%0d ready", n), 32'(req_ready), 32'd1);
      req_valid = 1'b1;
      req_we    = we;
      req_addr  = addr;
      req_wdata = wdata;
      @(negedge clk);
      req_valid = 1'b0;
      lat = 1;
      while (!rsp_valid && lat < 20) begin
         chk($sformatf("v%0d ready_low", n), 32'(req_ready), 32'd0);
         @(negedge clk);
         lat++;
      end
      chk($sformatf("v%0d latency", n), 32'(lat), 32'd3);
      chk($sformatf("v%0d rdata", n), 32'(rsp_rdata), 32'(exp_rd));
      chk($sformatf("v%0d err", n), 32'(rsp_err), 32'(exp_err));
      rd = rsp_rdata;
      @(negedge clk);
      chk($sformatf("v%0d strobe_len", n), 32'(rsp_valid), 32'd0);
      chk($sformatf("v%0d rdata_hold", n), 32'(rsp_rdata), 32'(rd));
      chk($sformatf("v%0d ready_back", n), 32'(req_ready), 32'd1);
   endtask

   // Hold req_valid for 'hold' cycles; count accepts, responses and the edge of the last accept.
   task automatic burst(input int sel, input int hold, input int exp_acc, input int exp_last);
      int acc, rsp, last;
      logic rdy, vld;
      acc = 0; rsp = 0; last = 0;
      do_reset();
      req_we = 1'b0;
      req_addr = 16'h0000;
      @(negedge clk);
      req_valid = 1'b1;
      for (int i = 0; i < hold; i++) begin
         rdy = (sel == 0) ? req_ready_z : req_ready_t;
         if (rdy) begin acc++; last = i + 1; end
         @(negedge clk);
         vld = (sel == 0) ? rsp_valid_z : rsp_valid_t;
         if (vld) rsp++;
      end
      req_valid = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         vld = (sel == 0) ? rsp_valid_z : rsp_valid_t;
         if (vld) rsp++;
      end
      chk($sformatf("burst%0d accepts", sel), 32'(acc), 32'(exp_acc));
      chk($sformatf("burst%0d responses", sel), 32'(rsp), 32'(exp_acc));
      chk($sformatf("burst%0d last_accept_edge", sel), 32'(last), 32'(exp_last));
   endtask

   initial begin
      int e_rd, e_wr, e_err, quiet;
      tbl[0] = '{1'b1, 16'h0000, 16'h1234, 16'h0000, 1'b0};
      tbl[1] = '{1'b1, 16'h0010, 16'hBEEF, 16'h0000, 1'b0};
      tbl[2] = '{1'b0, 16'h0010, 16'h0000, 16'hBEEF, 1'b0};
      tbl[3] = '{1'b0, 16'h0011, 16'h0000, 16'h0000, 1'b1};
      tbl[4] = '{1'b1, 16'h0200, 16'hDEAD, 16'h0000, 1'b1};
      tbl[5] = '{1'b0, 16'h0000, 16'h0000, 16'h1234, 1'b0};
      tbl[6] = '{1'b1, 16'h01FE, 16'h5A5A, 16'h0000, 1'b0};
      tbl[7] = '{1'b0, 16'h01FE, 16'h0000, 16'h5A5A, 1'b0};
      tbl[8] = '{1'b0, 16'h0200, 16'h0000, 16'h0000, 1'b1};
      tbl[9] = '{1'b1, 16'h0020, 16'h5555, 16'h0000, 1'b0};

      rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
      repeat (2) @(negedge clk);
      chk("rst ready", 32'(req_ready), 32'd1);
      chk("rst rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst rdata", 32'(rsp_rdata), 32'd0);
      chk("rst err", 32'(rsp_err), 32'd0);
      chk("rst stats", {stat_rd, stat_wr | stat_err}, 32'd0);
      chk("rst ready_z", 32'(req_ready_z), 32'd1);
      chk("rst ready_t", 32'(req_ready_t), 32'd1);
      rst = 1'b0;

      e_rd = 0; e_wr = 0; e_err = 0;
      foreach (tbl[i]) begin
         txn(i, tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].exp_rd, tbl[i].exp_err);
         if (tbl[i].exp_err) e_err++;
         else if (tbl[i].we) e_wr++;
         else e_rd++;
      end

`ifdef DMEM_STATS_EN
      chk("stat_rd", 32'(stat_rd), 32'(e_rd));
      chk("stat_wr", 32'(stat_wr), 32'(e_wr));
      chk("stat_err", 32'(stat_err), 32'(e_err));
      @(negedge clk);
      force dut.stat_rd_q = 16'hFFFF;
      @(negedge clk);
      release dut.stat_rd_q;
      txn(20, 1'b0, 16'h0010, 16'h0000, 16'hBEEF, 1'b0);
      chk("stat_rd saturate", 32'(stat_rd), 32'h0000FFFF);
`else
      chk("stat_rd off", 32'(stat_rd), 32'd0);
      chk("stat_wr off", 32'(stat_wr), 32'd0);
      chk("stat_err off", 32'(stat_err), 32'(e_err - e_err));
`endif

      // Reset while a store is waiting: no response, storage keeps the old word.
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b1; req_addr = 16'h0020; req_wdata = 16'hAAAA;
      @(negedge clk);
      req_valid = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("abort ready", 32'(req_ready), 32'd1);
      quiet = 0;
      for (int i = 0; i < 6; i++) begin
         if (rsp_valid) quiet++;
         @(negedge clk);
      end
      chk("abort no_rsp", 32'(quiet), 32'd0);
      txn(30, 1'b0, 16'h0020, 16'h0000, 16'h5555, 1'b0);

      burst(0, 6, 3, 5);
      burst(1, 15, 3, 11);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
